// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] fetch_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  input  logic        bp_clear,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic             res_hit;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[31:IDX_W+2];
  assign res_idx   = resolve_pc[IDX_W+1:2];
  assign res_tag   = resolve_pc[31:IDX_W+2];

  // Lookup reads only registered state, so a same-cycle update is never visible.
  always_comb begin
    pred_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pred_taken   = pred_hit && ctr_q[fetch_idx][CTR_W-1];
    pred_next_pc = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
  end

  always_comb begin
    res_hit     = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    mispredict  = resolve_valid &&
                  ((resolve_taken != resolve_pred_taken) ||
                   (resolve_taken && (resolve_target != resolve_pred_target)));
    redirect_pc = resolve_taken ? resolve_target : resolve_pc + 32'd4;
  end

  // NOTE: the whole table is cleared on reset (not just valid bits) so that
  // counters and targets start from a known value after every reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (bp_clear) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (resolve_valid) begin
      if (res_hit) begin
        if (resolve_taken) begin
          if (ctr_q[res_idx] != CTR_MAX) ctr_q[res_idx] <= ctr_q[res_idx] + CTR_W'(1);
          target_q[res_idx] <= resolve_target;
        end else if (ctr_q[res_idx] != '0) begin
          ctr_q[res_idx] <= ctr_q[res_idx] - CTR_W'(1);
        end
      end else if (resolve_taken) begin
        valid_q[res_idx]  <= 1'b1;
        tag_q[res_idx]    <= res_tag;
        target_q[res_idx] <= resolve_target;
        ctr_q[res_idx]    <= CTR_WEAK;
      end
    end
  end

`ifdef BP_STATS_EN
  // Statistics ignore bp_clear; they only clear on reset and saturate at all-ones.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (resolve_valid) begin
      if (stat_branches != '1) stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] fetch_pc;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_next_pc;
  logic        resolve_valid, resolve_taken, resolve_pred_taken, bp_clear;
  logic [31:0] resolve_pc, resolve_target, resolve_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predictor #(.ENTRIES(16), .CTR_W(2)) dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .fetch_pc            (fetch_pc),
    .pred_hit            (pred_hit),
    .pred_taken          (pred_taken),
    .pred_next_pc        (pred_next_pc),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .bp_clear            (bp_clear),
    .mispredict          (mispredict),
    .redirect_pc         (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches       (stat_branches),
    .stat_mispredicts    (stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    string       name;
    logic        is_stats;
    logic        hit;
    logic        taken;
    logic [31:0] next;
    logic        mis;
    logic        chk_redir;
    logic [31:0] redir;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t        sb[$];
  int          cycle = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so they are settled by the falling edge.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc == cycle) begin
      exp_t e;
      e = sb.pop_front();
      if (e.is_stats) begin
`ifdef BP_STATS_EN
        check({e.name, ".branches"},    stat_branches,    e.br);
        check({e.name, ".mispredicts"}, stat_mispredicts, e.mp);
`endif
      end else begin
        check({e.name, ".hit"},   {31'd0, pred_hit},   {31'd0, e.hit});
        check({e.name, ".taken"}, {31'd0, pred_taken}, {31'd0, e.taken});
        check({e.name, ".next"},  pred_next_pc,        e.next);
        check({e.name, ".mis"},   {31'd0, mispredict}, {31'd0, e.mis});
        if (e.chk_redir) check({e.name, ".redir"}, redirect_pc, e.redir);
      end
    end
  end

  // Drive one cycle and queue what the monitor must see in it.
  task automatic step(input string name, input logic [31:0] fpc,
                      input logic eh, input logic et, input logic [31:0] en,
                      input logic rv, input logic [31:0] rpc, input logic rt,
                      input logic [31:0] rtg, input logic rpt, input logic [31:0] rptg,
                      input logic emis, input logic [31:0] eredir, input logic clr);
    exp_t e;
    fetch_pc            = fpc;
    resolve_valid       = rv;
    resolve_pc          = rpc;
    resolve_taken       = rt;
    resolve_target      = rtg;
    resolve_pred_taken  = rpt;
    resolve_pred_target = rptg;
    bp_clear            = clr;
    e.cyc = cycle; e.name = name; e.is_stats = 1'b0;
    e.hit = eh; e.taken = et; e.next = en;
    e.mis = emis; e.chk_redir = rv; e.redir = eredir;
    e.br = '0; e.mp = '0;
    sb.push_back(e);
    if (rv && nRST) begin
      exp_br++;
      if (emis) exp_mp++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input string name, input logic [31:0] fpc,
                      input logic eh, input logic et, input logic [31:0] en);
    step(name, fpc, eh, et, en, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic stats(input string name);
    exp_t e;
    e.cyc = cycle; e.name = name; e.is_stats = 1'b1;
    e.hit = 1'b0; e.taken = 1'b0; e.next = '0; e.mis = 1'b0;
    e.chk_redir = 1'b0; e.redir = '0; e.br = exp_br; e.mp = exp_mp;
    sb.push_back(e);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0;
    fetch_pc = '0; resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
    resolve_target = '0; resolve_pred_taken = 1'b0; resolve_pred_target = '0; bp_clear = 1'b0;
    @(posedge CLK);
    #1;
    idle("in_reset", 32'h40, 1'b0, 1'b0, 32'h44);
    nRST = 1'b1;
    exp_br = 0; exp_mp = 0;
    idle("post_reset", 32'h40, 1'b0, 1'b0, 32'h44);
    stats("stats_reset");
    //   name        fetch        hit   tk    next         rv    rpc          rt    rtarget     rpt   rptarget  mis   redir       clr
    step("alloc",    32'h40,      1'b0, 1'b0, 32'h44,      1'b1, 32'h40,      1'b1, 32'h80,     1'b0, 32'h44,   1'b1, 32'h80,     1'b0);
    step("nt1",      32'h40,      1'b1, 1'b1, 32'h80,      1'b1, 32'h40,      1'b0, 32'h0,      1'b1, 32'h80,   1'b1, 32'h44,     1'b0);
    step("nt2",      32'h40,      1'b1, 1'b0, 32'h44,      1'b1, 32'h40,      1'b0, 32'h0,      1'b0, 32'h44,   1'b0, 32'h44,     1'b0);
    step("nt_sat",   32'h40,      1'b1, 1'b0, 32'h44,      1'b1, 32'h40,      1'b0, 32'h0,      1'b0, 32'h44,   1'b0, 32'h44,     1'b0);
    step("t_up1",    32'h40,      1'b1, 1'b0, 32'h44,      1'b1, 32'h40,      1'b1, 32'h80,     1'b0, 32'h44,   1'b1, 32'h80,     1'b0);
    step("t_up2",    32'h40,      1'b1, 1'b0, 32'h44,      1'b1, 32'h40,      1'b1, 32'h80,     1'b0, 32'h44,   1'b1, 32'h80,     1'b0);
    step("tgt_chg",  32'h40,      1'b1, 1'b1, 32'h80,      1'b1, 32'h40,      1'b1, 32'h90,     1'b1, 32'h80,   1'b1, 32'h90,     1'b0);
    step("t_sat",    32'h40,      1'b1, 1'b1, 32'h90,      1'b1, 32'h40,      1'b1, 32'h90,     1'b1, 32'h90,   1'b0, 32'h90,     1'b0);
    step("nt_hi",    32'h40,      1'b1, 1'b1, 32'h90,      1'b1, 32'h40,      1'b0, 32'h0,      1'b1, 32'h90,   1'b1, 32'h44,     1'b0);
    step("alias",    32'h40,      1'b1, 1'b1, 32'h90,      1'b1, 32'h80,      1'b1, 32'h200,    1'b0, 32'h84,   1'b1, 32'h200,    1'b0);
    idle("alias_old", 32'h40,     1'b0, 1'b0, 32'h44);
    step("miss_nt",  32'h80,      1'b1, 1'b1, 32'h200,     1'b1, 32'hC4,      1'b0, 32'h0,      1'b0, 32'hC8,   1'b0, 32'hC8,     1'b0);
    step("clear",    32'hC4,      1'b0, 1'b0, 32'hC8,      1'b1, 32'h40,      1'b1, 32'h100,    1'b0, 32'h44,   1'b1, 32'h100,    1'b1);
    idle("clr_40",   32'h40,      1'b0, 1'b0, 32'h44);
    step("wrap",     32'h80,      1'b0, 1'b0, 32'h84,      1'b1, 32'hFFFFFFFC, 1'b0, 32'h0,     1'b1, 32'h1000, 1'b1, 32'h0,      1'b0);
    step("lowbits",  32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,      1'b1, 32'h12,      1'b1, 32'h300,    1'b0, 32'h16,   1'b1, 32'h300,    1'b0);
    stats("stats_run");
    idle("low_hit",  32'h10,      1'b1, 1'b1, 32'h300);
    nRST = 1'b0;
    step("rst_mid",  32'h24,      1'b0, 1'b0, 32'h28,      1'b1, 32'h24,      1'b1, 32'h400,    1'b0, 32'h28,   1'b1, 32'h400,    1'b0);
    nRST = 1'b1;
    exp_br = 0; exp_mp = 0;
    stats("stats_rst_mid");
    idle("rst_drop", 32'h24,      1'b0, 1'b0, 32'h28);
    idle("rst_clr",  32'h10,      1'b0, 1'b0, 32'h14);
    repeat (2) @(posedge CLK);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with per-entry saturating direction counters for the 5-stage pipelined datapath. The fetch stage looks up the current PC combinationally and gets a predicted next PC. The execute stage reports each resolved branch or jump, and the block updates its table and flags mispredictions so the hazard unit can flush IF/ID and ID/EX. This replaces resolve-in-EX with no prediction: correctly predicted taken branches no longer cost a flush.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2; IDX_W = log2(ENTRIES)
- CTR_W, 2, direction counter width in bits; minimum 1

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, synchronous, active-low
- fetch_pc  in  32  PC being fetched this cycle
- pred_hit  out  1  fetch_pc hits a valid entry with a matching tag
- pred_taken  out  1  prediction is taken: pred_hit AND counter MSB set
- pred_next_pc  out  32  stored target if pred_taken, else fetch_pc + 4
- resolve_valid  in  1  EX holds a resolved control-transfer instruction this cycle; caller gates with stall
- resolve_pc  in  32  PC of the resolving instruction
- resolve_taken  in  1  actual outcome; 1 for all jumps
- resolve_target  in  32  actual taken target
- resolve_pred_taken  in  1  pred_taken value carried down the pipe with the instruction
- resolve_pred_target  in  32  pred_next_pc value carried down the pipe
- bp_clear  in  1  synchronous invalidate of all entries
- mispredict  out  1  redirect required; flush younger stages
- redirect_pc  out  32  correct next PC when mispredict is 1
- stat_branches  out  32  resolved count; present only with BP_STATS_EN
- stat_mispredicts  out  32  mispredict count; present only with BP_STATS_EN

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]. pc[1:0] is ignored.
- Entry state: valid, tag, target[31:0], ctr[CTR_W-1:0].
- Lookup is purely combinational from table state: pred_* depend only on fetch_pc and registered contents.
- mispredict = resolve_valid AND (resolve_taken != resolve_pred_taken OR (resolve_taken AND resolve_target != resolve_pred_target)).
- redirect_pc = resolve_taken ? resolve_target : resolve_pc + 4. Arithmetic is modulo 2^32: PC 0xFFFFFFFC + 4 wraps to 0.
- Update on the edge where resolve_valid=1, at index(resolve_pc):
  - Hit, taken: ctr saturating +1, target ← resolve_target.
  - Hit, not taken: ctr saturating −1; target unchanged.
  - Miss, taken: allocate by overwriting the indexed entry. valid=1, tag and target written, ctr = 2^(CTR_W−1), i.e. weakly taken.
  - Miss, not taken: no table change.
- Counters saturate at 0 and 2^CTR_W−1; they never wrap.
- When CTR_W=1 the counter is a last-outcome bit, and allocation sets it to 1.

## Timing
- Prediction has zero latency: same-cycle combinational from fetch_pc.
- mispredict and redirect_pc are combinational from the resolve_* inputs in the same cycle; the table update lands on the following edge.
- Same-cycle lookup and update of the same index: lookup returns the pre-update contents. There is no bypass.
- bp_clear=1 clears every valid bit on the edge and takes priority over a simultaneous resolve update. Counters need not clear.
- Reset (nRST=0 at an edge): all valid=0, all ctr=0, all targets=0, stats=0.
  - Reset mid-operation discards any pending update in that cycle.
  - While nRST=0 the outputs follow the combinational rules with all entries invalid, so pred_hit=0 and pred_next_pc=fetch_pc+4. mispredict still reflects resolve_* unless the caller deasserts resolve_valid.

## Configuration
- BP_STATS_EN defined: stat_branches increments on every resolve_valid edge. stat_mispredicts increments when mispredict=1 on that edge. Both saturate at 0xFFFFFFFF, clear on reset, and are not affected by bp_clear.
- BP_STATS_EN undefined: both stat ports and their counters are absent; all other behaviour is identical.

## Test plan
- Reset, then fetch_pc=0x40 → pred_hit=0, pred_taken=0, pred_next_pc=0x44.
- Resolve taken branch at 0x40 with target 0x80 and pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle fetch_pc=0x40 → pred_hit=1, pred_taken=1, pred_next_pc=0x80.
- Same branch resolved not-taken twice (CTR_W=2): counter goes 10→01→00, fetch then predicts 0x44. The first of those resolves with resolve_pred_taken=1 → mispredict=1, redirect_pc=0x44.
- Alias test (ENTRIES=16): 0x40 allocated, then taken at 0x80 (same index 0, different tag) → 0x40 now misses, 0x80 hits.
- Simultaneous resolve(0x40, taken→0x100) and bp_clear=1 → all lookups miss afterward. Separately, a same-cycle lookup of 0x40 during its update returns the old target.
- With BP_STATS_EN: 5 resolves including 2 mispredicts → stat_branches=5, stat_mispredicts=2. Reset clears both to 0.
